// File: rtl/lu_pkg.sv
// Shared constants for the 2-input, 8-operation logic unit and its identifier.
// Truth tables are indexed by {x,y}, so bit 3 is x=1,y=1 and bit 0 is x=0,y=0.
package lu_pkg;

  localparam logic [2:0] OP_NOTX = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;

  localparam logic [3:0] TT_NOTX = 4'b0011;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_ZERO = 4'b0000;

  typedef enum logic [1:0] {
    StIdle,
    StProbe,
    StDecode,
    StReport
  } lu_state_e;

endpackage

// File: rtl/lu_identifier_if.sv
// Probe/result bundle between the identifier and whoever drives and observes it.
interface lu_identifier_if;
  logic       start;
  logic       w;
  logic       x;
  logic       y;
  logic       busy;
  logic       done;
  logic [2:0] e;
  logic       valid;
  logic       stable;

  modport master (output start, w, input x, y, busy, done, e, valid, stable);
  modport slave  (input start, w, output x, y, busy, done, e, valid, stable);
endinterface

// File: rtl/lu_decode.sv
// Combinational map from an observed 4-bit truth table back to the select code.
module lu_decode
  import lu_pkg::*;
(
  input  logic [3:0] tt_i,
  output logic       match_o,
  output logic [2:0] code_o
);

  always_comb begin
    match_o = 1'b1;
    code_o  = 3'b000;
    case (tt_i)
      TT_NOTX: code_o = OP_NOTX;
      TT_AND:  code_o = OP_AND;
      TT_NAND: code_o = OP_NAND;
      TT_XOR:  code_o = OP_XOR;
      TT_XNOR: code_o = OP_XNOR;
      TT_OR:   code_o = OP_OR;
      TT_NOR:  code_o = OP_NOR;
      TT_ZERO: code_o = OP_ZERO;
      default: match_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/lu_identifier.sv
// Sweeps {x,y} through all four vectors for PASSES passes, builds the truth table
// of the unit under probe from w, and reports the recovered select code.
module lu_identifier
  import lu_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned PASSES = 2
) (
  input logic            clk,
  input logic            rst,
  lu_identifier_if.slave bus
);

  localparam int unsigned CntW     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE);
  localparam logic [3:0] LastPass  = 4'(PASSES - 1);

  lu_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      pass_q, pass_d;
  logic [3:0]      tt_q, tt_d;
  logic            agree_q, agree_d;
  logic            x_q, x_d;
  logic            y_q, y_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2:0]      e_q, e_d;
  logic            valid_q, valid_d;
  logic            stable_q, stable_d;

  logic            dec_match;
  logic [2:0]      dec_code;

  lu_decode u_decode (
    .tt_i    (tt_q),
    .match_o (dec_match),
    .code_o  (dec_code)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pass_d   = pass_q;
    tt_d     = tt_q;
    agree_d  = agree_q;
    x_d      = x_q;
    y_d      = y_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    e_d      = e_q;
    valid_d  = valid_q;
    stable_d = stable_q;

    unique case (state_q)
      StIdle: begin
        x_d = 1'b0;
        y_d = 1'b0;
        if (bus.start) begin
          state_d = StProbe;
          busy_d  = 1'b1;
          cnt_d   = CntLoad;
          idx_d   = 2'd0;
          pass_d  = 4'd0;
          agree_d = 1'b1;
        end
      end
      StProbe: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          cnt_d = CntLoad;
          idx_d = idx_q + 2'd1;
          // Pass 0 captures the reference table; later passes only check against it.
          if (pass_q == 4'd0) begin
            tt_d[idx_q] = bus.w;
          end else if (tt_q[idx_q] != bus.w) begin
            agree_d = 1'b0;
          end
          if (idx_q == 2'd3) begin
            pass_d = pass_q + 4'd1;
            if (pass_q == LastPass) begin
              state_d = StDecode;
            end
          end
        end
        {x_d, y_d} = idx_d;
      end
      StDecode: begin
        state_d = StReport;
      end
      StReport: begin
        state_d  = StIdle;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        stable_d = agree_q;
        valid_d  = dec_match & agree_q;
        e_d      = (dec_match & agree_q) ? dec_code : 3'b000;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      pass_q   <= 4'd0;
      tt_q     <= 4'b0000;
      agree_q  <= 1'b0;
      x_q      <= 1'b0;
      y_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      e_q      <= 3'b000;
      valid_q  <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pass_q   <= pass_d;
      tt_q     <= tt_d;
      agree_q  <= agree_d;
      x_q      <= x_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      e_q      <= e_d;
      valid_q  <= valid_d;
      stable_q <= stable_d;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.e      = e_q;
  assign bus.valid  = valid_q;
  assign bus.stable = stable_q;

endmodule

// File: doc/lu_identifier.md
# lu_identifier

Sequential prober that recovers the 3-bit function-select code (e2 e1 e0) of the 2-input, 8-operation logic unit from its output alone. On `start` it drives the unit's `x`/`y` inputs through all four combinations, samples `w`, and builds a 4-bit truth table. It repeats the sweep for a configurable number of passes and decodes the table back to the select code. It sits on the opposite side of the logic unit: the unit maps code to function, this block maps observed function to code, for self-test and bench cross-checking.

## Interface
- `SETTLE`, 1: extra cycles between driving a probe vector and sampling `w` (0 allowed).
- `PASSES`, 2: number of full 4-vector sweeps that must agree (1..15).
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin identification; accepted only in IDLE.
- `w`  in  1  output of the logic unit under probe.
- `x`  out  1  probe drive to unit input x (registered).
- `y`  out  1  probe drive to unit input y (registered).
- `busy`  out  1  high from start acceptance until done.
- `done`  out  1  one-cycle pulse when results are updated.
- `e`  out  3  recovered select code {e2,e1,e0}; held until next done.
- `valid`  out  1  truth table matched a known code and all passes agreed.
- `stable`  out  1  all passes produced identical tables.

## Operation
- States: IDLE, PROBE, DECODE, REPORT.
- IDLE: `x`=`y`=0. `start`=1 moves to PROBE with vector index 0, pass 0, settle counter = `SETTLE`.
- PROBE: `{x,y}` = index (00, 01, 10, 11).
  - Counter decrements each cycle.
  - At the edge where the counter is 0, `w` is written to `tt[index]`, the index advances, and the counter reloads.
  - On pass 0, bits are stored in `tt`. On later passes, each bit is compared against `tt[index]`; any difference clears the internal stable flag (sticky per run).
  - After index 3 of pass `PASSES-1`, go to DECODE.
- DECODE (1 cycle): combinational map of `{tt3,tt2,tt1,tt0}`:
  - 0011 -> 000 (NOT x)
  - 1000 -> 001 (AND)
  - 0111 -> 010 (NAND)
  - 0110 -> 011 (XOR)
  - 1001 -> 100 (XNOR)
  - 1110 -> 101 (OR)
  - 0001 -> 110 (NOR)
  - 0000 -> 111 (constant 0)
  - Any other pattern -> no match.
- REPORT (1 cycle): register `e`, `valid`, `stable`; `done`=1, `busy`=0; return to IDLE.
  - `valid` = match AND stable.
  - `e` = 000 whenever `valid`=0.
- `start` while not IDLE is ignored. `start` held high re-triggers a new run from IDLE on the cycle after REPORT.
- Reset values: `x`=0, `y`=0, `busy`=0, `done`=0, `e`=000, `valid`=0, `stable`=0, state IDLE, `tt`=0000.
- Reset mid-run aborts immediately; no `done` is produced and previous results are lost (reset values).

## Timing
- `start` sampled high at edge k:
  - `busy`=1 and `x,y`=00 from edge k.
  - First sample at edge k+SETTLE+1.
- Each vector occupies SETTLE+1 cycles; one pass is 4*(SETTLE+1) cycles.
- Last sample at edge k+PASSES*4*(SETTLE+1).
- DECODE on the next edge; `done`/results valid after edge k+PASSES*4*(SETTLE+1)+2, for one cycle.
- `w` must settle within SETTLE+1 cycles of the `x`/`y` change. With a combinational unit, SETTLE=0 is sufficient.
- `e`, `valid` and `stable` change only on the REPORT edge or on reset.

## Structure
- Shared package `lu_pkg` holds:
  - op-code localparams OP_NOTX..OP_ZERO (000..111);
  - truth-table constants TT_NOTX=4'b0011 ... TT_ZERO=4'b0000;
  - state encoding.
  - The logic-unit bench uses the same constants.
- One sub-module, `lu_decode`: purely combinational `tt[3:0]` -> {match, code[2:0]}, reusable by the bench scoreboard.
- Counter widths: settle counter $clog2(SETTLE+1) (min 1 bit); pass counter 4 bits.

## Test plan
- Logic unit with select 011, SETTLE=0, PASSES=2, start pulse -> `x,y` sequence 00,01,10,11 twice; `done` 10 cycles after start edge; `e`=011, `valid`=1, `stable`=1.
- Sweep all 8 select codes back-to-back, SETTLE=1 -> each run reports `e` equal to the applied code with `valid`=1; select 111 reports `e`=111.
- `w` forced to x&~y (pattern 0100) -> `valid`=0, `stable`=1, `e`=000.
- Select toggled 001 -> 101 between pass 0 and pass 1 -> `stable`=0, `valid`=0, `e`=000.
- `start` pulsed again mid-run, then `rst` asserted at cycle 3 of a run -> second start ignored; on reset, outputs return to reset values at once with no `done`; a fresh start then completes normally.
- `start` held high continuously, select 101 -> `done` pulses periodically every PASSES*4*(SETTLE+1)+3 cycles, each with `e`=101.
